// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcodes, the abort result pattern and the arbiter state encoding.
package fpu_pkg;

  localparam logic [3:0] FPU_OP_ADD  = 4'b0000;
  localparam logic [3:0] FPU_OP_SUB  = 4'b0001;
  localparam logic [3:0] FPU_OP_MUL  = 4'b0010;
  localparam logic [3:0] FPU_OP_DIV  = 4'b0011;
  localparam logic [3:0] FPU_OP_SQRT = 4'b0100;
  localparam logic [3:0] FPU_OP_MIN  = 4'b0101;
  localparam logic [3:0] FPU_OP_MAX  = 4'b0110;
  localparam logic [3:0] FPU_OP_CMP  = 4'b0111;

  localparam logic [31:0] FPU_NAN = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DELIVER
  } fpu_arb_state_t;

  // Index width for n requesters, never below one bit
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester-side and fpu-side handshake bundles for the shared fpu arbiter.
interface fpu_req_if #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned OP_WIDTH = 4
);
  logic [N_REQ-1:0]          req_input_rdy;
  logic [N_REQ*OP_WIDTH-1:0] req_operation;
  logic [N_REQ*WIDTH-1:0]    req_data_a;
  logic [N_REQ*WIDTH-1:0]    req_data_b;
  logic [N_REQ-1:0]          req_input_ack;
  logic [N_REQ-1:0]          rsp_output_rdy;
  logic [N_REQ-1:0]          rsp_output_ack;
  logic [WIDTH-1:0]          rsp_result;
  logic                      rsp_error;

  modport master (
    output req_input_rdy, req_operation, req_data_a, req_data_b, rsp_output_ack,
    input  req_input_ack, rsp_output_rdy, rsp_result, rsp_error
  );

  modport slave (
    input  req_input_rdy, req_operation, req_data_a, req_data_b, rsp_output_ack,
    output req_input_ack, rsp_output_rdy, rsp_result, rsp_error
  );
endinterface

interface fpu_core_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned OP_WIDTH = 4
);
  logic [OP_WIDTH-1:0] fpu_operation;
  logic [WIDTH-1:0]    fpu_data_a;
  logic [WIDTH-1:0]    fpu_data_b;
  logic                fpu_input_rdy;
  logic                fpu_input_ack;
  logic                fpu_output_rdy;
  logic                fpu_output_ack;
  logic [WIDTH-1:0]    fpu_result;

  modport master (
    output fpu_operation, fpu_data_a, fpu_data_b, fpu_input_rdy, fpu_output_ack,
    input  fpu_input_ack, fpu_output_rdy, fpu_result
  );

  modport slave (
    input  fpu_operation, fpu_data_a, fpu_data_b, fpu_input_rdy, fpu_output_ack,
    output fpu_input_ack, fpu_output_rdy, fpu_result
  );
endinterface

// File: rtl/fpu_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W:0]      sum;

  // Rotating a doubled vector puts the pointer position at bit 0
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    sum   = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (!any && rot[off]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (ID_W + 1)'(off);
        if (sum >= (ID_W + 1)'(N_REQ)) begin
          sum = sum - (ID_W + 1)'(N_REQ);
        end
        idx   = sum[ID_W-1:0];
        grant = N_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fpu among N_REQ requesters: round-robin pick, issue, wait with watchdog, deliver.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter  int unsigned N_REQ    = 4,
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned OP_WIDTH = 4,
  parameter  int unsigned TIMEOUT  = 64,
  localparam int unsigned ID_W     = id_width(N_REQ)
) (
  input  logic            clock,
  input  logic            reset,
  fpu_req_if.slave        req,
  fpu_core_if.master      fpu,
  output logic            busy,
  output logic [ID_W-1:0] grant_id
);

  localparam int unsigned WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  fpu_arb_state_t      state;
  logic [ID_W-1:0]     rr_ptr;
  logic [WD_W-1:0]     wdog;
  logic                ack_seen;
  logic [OP_WIDTH-1:0] op_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;

  logic [N_REQ-1:0]    pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                rsp_ack_g;
  logic                deliver_done;
  logic [N_REQ-1:0]    grant_oh;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (req.req_input_rdy),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign fpu.fpu_operation = op_q;
  assign fpu.fpu_data_a    = a_q;
  assign fpu.fpu_data_b    = b_q;
  assign busy              = (state != ARB_IDLE);
  assign grant_oh          = N_REQ'(1) << grant_id;
  assign rsp_ack_g         = req.rsp_output_ack[grant_id];
  // Requester ack and fpu output_rdy release may arrive in either order
  assign deliver_done      = (ack_seen || rsp_ack_g) && !fpu.fpu_output_rdy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= ARB_IDLE;
      rr_ptr             <= '0;
      wdog               <= '0;
      ack_seen           <= 1'b0;
      op_q               <= '0;
      a_q                <= '0;
      b_q                <= '0;
      grant_id           <= '0;
      req.req_input_ack  <= '0;
      req.rsp_output_rdy <= '0;
      req.rsp_result     <= '0;
      req.rsp_error      <= 1'b0;
      fpu.fpu_input_rdy  <= 1'b0;
      fpu.fpu_output_ack <= 1'b0;
    end else begin
      req.req_input_ack <= '0;
      unique case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            op_q              <= req.req_operation[pick_idx*OP_WIDTH +: OP_WIDTH];
            a_q               <= req.req_data_a[pick_idx*WIDTH +: WIDTH];
            b_q               <= req.req_data_b[pick_idx*WIDTH +: WIDTH];
            grant_id          <= pick_idx;
            req.req_input_ack <= pick_grant;
            fpu.fpu_input_rdy <= 1'b1;
            state             <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (fpu.fpu_input_ack) begin
            fpu.fpu_input_rdy <= 1'b0;
            wdog              <= '0;
            state             <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (fpu.fpu_output_rdy) begin
            req.rsp_result     <= fpu.fpu_result;
            req.rsp_error      <= 1'b0;
            req.rsp_output_rdy <= grant_oh;
            fpu.fpu_output_ack <= 1'b1;
            ack_seen           <= 1'b0;
            state              <= ARB_DELIVER;
          end else if (TIMEOUT != 0 && wdog == WD_W'(WD_LAST)) begin
            req.rsp_result     <= WIDTH'(FPU_NAN);
            req.rsp_error      <= 1'b1;
            req.rsp_output_rdy <= grant_oh;
            ack_seen           <= 1'b0;
            state              <= ARB_DELIVER;
          end else if (TIMEOUT != 0) begin
            wdog <= wdog + 1'b1;
          end
        end
        ARB_DELIVER: begin
          if (rsp_ack_g) begin
            ack_seen <= 1'b1;
          end
          if (!fpu.fpu_output_rdy) begin
            fpu.fpu_output_ack <= 1'b0;
          end
          if (deliver_done) begin
            rr_ptr             <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            req.rsp_output_rdy <= '0;
            ack_seen           <= 1'b0;
            state              <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a programmable-latency fpu model.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  logic       clock;
  logic       reset;
  logic       busy;
  logic [1:0] grant_id;

  fpu_req_if  #(.N_REQ(4), .WIDTH(32), .OP_WIDTH(4)) reqbus ();
  fpu_core_if #(.WIDTH(32), .OP_WIDTH(4))            fpubus ();

  fpu_arbiter #(
    .N_REQ    (4),
    .WIDTH    (32),
    .OP_WIDTH (4),
    .TIMEOUT  (64)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (reqbus),
    .fpu      (fpubus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  int          in_lat   = 0;
  int          out_lat  = 0;
  bit          never_rsp   = 1'b0;
  bit          res_xor     = 1'b0;
  bit          model_flush = 1'b0;
  bit          auto_ack    = 1'b0;
  logic [31:0] fix_res  = '0;
  logic [3:0]  cap_op;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  int          grants[$];

  int          exp_order[5] = '{0, 1, 2, 3, 0};
  logic [31:0] exp_res[5]   = '{32'hA5A5_1111, 32'hA5A5_2222, 32'hA5A5_3333,
                                32'hA5A5_4444, 32'hDEAD_BEEF};

  typedef enum int {M_IDLE, M_ACK, M_BUSY, M_OUT} mstate_t;

  // fpu model: input_ack after in_lat cycles of input_rdy, result after out_lat
  initial begin
    mstate_t ms;
    int      cnt;
    ms  = M_IDLE;
    cnt = 0;
    fpubus.fpu_input_ack  = 1'b0;
    fpubus.fpu_output_rdy = 1'b0;
    fpubus.fpu_result     = '0;
    forever begin
      @(posedge clock); #1;
      if (!reset || model_flush) begin
        ms = M_IDLE;
        cnt = 0;
        fpubus.fpu_input_ack  = 1'b0;
        fpubus.fpu_output_rdy = 1'b0;
      end else begin
        case (ms)
          M_IDLE: if (fpubus.fpu_input_rdy === 1'b1) begin
            if (cnt >= in_lat) begin
              fpubus.fpu_input_ack = 1'b1;
              cap_op = fpubus.fpu_operation;
              cap_a  = fpubus.fpu_data_a;
              cap_b  = fpubus.fpu_data_b;
              ms = M_ACK;
            end else begin
              cnt++;
            end
          end
          M_ACK: begin
            fpubus.fpu_input_ack = 1'b0;
            cnt = 0;
            if (!never_rsp && out_lat == 0) begin
              fpubus.fpu_result     = res_xor ? (cap_a ^ cap_b) : fix_res;
              fpubus.fpu_output_rdy = 1'b1;
              ms = M_OUT;
            end else begin
              ms = M_BUSY;
            end
          end
          M_BUSY: if (!never_rsp) begin
            cnt++;
            if (cnt >= out_lat) begin
              fpubus.fpu_result     = res_xor ? (cap_a ^ cap_b) : fix_res;
              fpubus.fpu_output_rdy = 1'b1;
              ms = M_OUT;
            end
          end
          M_OUT: if (fpubus.fpu_output_ack === 1'b1) begin
            fpubus.fpu_output_rdy = 1'b0;
            cnt = 0;
            ms = M_IDLE;
          end
          default: ms = M_IDLE;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle; requesters drop on ack and optionally consume results at once
  task automatic tick();
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      if (reqbus.req_input_ack[i] === 1'b1) begin
        reqbus.req_input_rdy[i] = 1'b0;
        grants.push_back(i);
      end
    end
    if (auto_ack) reqbus.rsp_output_ack = reqbus.rsp_output_rdy;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    reqbus.req_operation[i*4 +: 4] = op;
    reqbus.req_data_a[i*32 +: 32]  = a;
    reqbus.req_data_b[i*32 +: 32]  = b;
    reqbus.req_input_rdy[i]        = 1'b1;
  endtask

  task automatic wait_rsp(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (reqbus.rsp_output_rdy === 4'b0000 && cycles < budget) begin
      tick();
      cycles++;
    end
    check({tag, "_rsp_in_budget"}, (reqbus.rsp_output_rdy !== 4'b0000), 1);
  endtask

  task automatic finish_op(input string tag);
    auto_ack = 1'b1;
    reqbus.rsp_output_ack = reqbus.rsp_output_rdy;
    for (int c = 0; c < 20 && busy !== 1'b0; c++) tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic flush_model();
    model_flush = 1'b1;
    tick();
    tick();
    never_rsp   = 1'b0;
    model_flush = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_in_ack"},   reqbus.req_input_ack, 0);
    check({tag, "_out_rdy"},  reqbus.rsp_output_rdy, 0);
    check({tag, "_result"},   {reqbus.rsp_error, reqbus.rsp_result}, 0);
    check({tag, "_fpu_hs"},   {fpubus.fpu_input_rdy, fpubus.fpu_output_ack}, 0);
    check({tag, "_fpu_data"}, {fpubus.fpu_operation, fpubus.fpu_data_a, fpubus.fpu_data_b}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int          cyc;
    int          deliveries;
    bit          prev_rdy;
    bit          re0;
    logic [3:0]  oh;
    logic [31:0] hold_a;
    logic [31:0] hold_b;

    reset = 1'b0;
    reqbus.req_input_rdy  = '0;
    reqbus.req_operation  = '0;
    reqbus.req_data_a     = '0;
    reqbus.req_data_b     = '0;
    reqbus.rsp_output_ack = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // 1: single add from requester 0
    fix_res = 32'h3F81_47AE;
    set_req(0, FPU_OP_ADD, 32'h3F80_0000, 32'h3C23_D70A);
    tick();
    check("t1_in_ack", reqbus.req_input_ack, 4'b0001);
    check("t1_fpu_rdy", fpubus.fpu_input_rdy, 1);
    check("t1_fpu_data", {fpubus.fpu_operation, fpubus.fpu_data_a, fpubus.fpu_data_b},
          {FPU_OP_ADD, 32'h3F80_0000, 32'h3C23_D70A});
    wait_rsp("t1", 10, cyc);
    check("t1_latency", cyc, 2);
    check("t1_out_rdy", reqbus.rsp_output_rdy, 4'b0001);
    check("t1_result", {reqbus.rsp_error, reqbus.rsp_result}, {1'b0, 32'h3F81_47AE});
    check("t1_fpu_cap", {cap_op, cap_a, cap_b}, {FPU_OP_ADD, 32'h3F80_0000, 32'h3C23_D70A});
    finish_op("t1");

    // 2: all four requesters together after reset, requester 0 re-raised during its delivery
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    grants.delete();
    res_xor = 1'b1;
    out_lat = 1;
    auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, FPU_OP_MUL, 32'h0000_1111 * (i + 1), 32'hA5A5_0000);
    deliveries = 0;
    prev_rdy = 1'b0;
    re0 = 1'b0;
    for (int c = 0; c < 400 && !(deliveries == 5 && busy === 1'b0); c++) begin
      tick();
      if (reqbus.rsp_output_rdy !== 4'b0000 && !prev_rdy && deliveries < 5) begin
        oh = 4'b0001 << exp_order[deliveries];
        check("t2_out_rdy", reqbus.rsp_output_rdy, oh);
        check("t2_result", reqbus.rsp_result, exp_res[deliveries]);
        deliveries++;
        if (!re0) begin
          set_req(0, FPU_OP_SUB, 32'hDEAD_0000, 32'h0000_BEEF);
          re0 = 1'b1;
        end
      end
      prev_rdy = (reqbus.rsp_output_rdy !== 4'b0000);
    end
    check("t2_deliveries", deliveries, 5);
    check("t2_grant_count", grants.size(), 5);
    for (int k = 0; k < 5 && k < grants.size(); k++) check("t2_grant_order", grants[k], exp_order[k]);

    // 3: fpu input_ack held off for 5 cycles
    res_xor = 1'b0;
    out_lat = 0;
    in_lat = 5;
    fix_res = 32'h3FC9_0FDB;
    set_req(2, FPU_OP_DIV, 32'h4049_0FDB, 32'h4000_0000);
    tick();
    check("t3_in_ack", reqbus.req_input_ack, 4'b0100);
    check("t3_grant_id", grant_id, 2);
    hold_a = fpubus.fpu_data_a;
    hold_b = fpubus.fpu_data_b;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_fpu_rdy_held", fpubus.fpu_input_rdy, 1);
      check("t3_data_a_held", fpubus.fpu_data_a, hold_a);
      check("t3_data_b_held", fpubus.fpu_data_b, hold_b);
      check("t3_single_ack", reqbus.req_input_ack, 0);
    end
    tick();
    check("t3_fpu_rdy_drop", fpubus.fpu_input_rdy, 0);
    check("t3_data_a_val", hold_a, 32'h4049_0FDB);
    wait_rsp("t3", 10, cyc);
    check("t3_result", {reqbus.rsp_error, reqbus.rsp_result}, {1'b0, 32'h3FC9_0FDB});
    finish_op("t3");
    in_lat = 0;

    // 4: fpu never answers, watchdog aborts after 64 WAIT cycles
    never_rsp = 1'b1;
    set_req(3, FPU_OP_SQRT, 32'h4080_0000, 32'h0000_0000);
    tick();
    check("t4_in_ack", reqbus.req_input_ack, 4'b1000);
    wait_rsp("t4", 100, cyc);
    check("t4_abort_latency", cyc, 65);
    check("t4_out_rdy", reqbus.rsp_output_rdy, 4'b1000);
    check("t4_result", {reqbus.rsp_error, reqbus.rsp_result}, {1'b1, 32'hFFFF_FFFF});
    check("t4_no_fpu_ack", fpubus.fpu_output_ack, 0);
    finish_op("t4");
    flush_model();

    // 5: result held while requester 0 withholds its ack; requester 1 waits
    auto_ack = 1'b0;
    reqbus.rsp_output_ack = '0;
    out_lat = 2;
    fix_res = 32'h4049_0FDB;
    set_req(0, FPU_OP_MUL, 32'h3FC9_0FDB, 32'h4000_0000);
    wait_rsp("t5", 20, cyc);
    set_req(1, FPU_OP_ADD, 32'h4000_0000, 32'h4000_0000);
    reqbus.rsp_output_ack = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_out_rdy_held", reqbus.rsp_output_rdy, 4'b0001);
      check("t5_result_held", reqbus.rsp_result, 32'h4049_0FDB);
      check("t5_no_ack1", reqbus.req_input_ack, 0);
    end
    reqbus.rsp_output_ack = 4'b0001;
    tick();
    check("t5_exit_rdy", reqbus.rsp_output_rdy, 0);
    check("t5_exit_busy", busy, 0);
    reqbus.rsp_output_ack = '0;
    fix_res = 32'h4080_0000;
    tick();
    check("t5_req1_ack", reqbus.req_input_ack, 4'b0010);
    check("t5_req1_grant", grant_id, 1);
    auto_ack = 1'b1;
    wait_rsp("t5b", 20, cyc);
    check("t5_req1_result", {reqbus.rsp_output_rdy, reqbus.rsp_result}, {4'b0010, 32'h4080_0000});
    finish_op("t5");

    // 6: reset pulse during WAIT drops the operation
    out_lat = 0;
    never_rsp = 1'b1;
    set_req(3, FPU_OP_SUB, 32'h4000_0000, 32'h3F80_0000);
    tick();
    check("t6_in_ack", reqbus.req_input_ack, 4'b1000);
    tick();
    tick();
    check("t6_in_wait", {busy, fpubus.fpu_input_rdy}, 2'b10);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_all_zero("t6_reset");
    flush_model();
    fix_res = 32'h3F80_0000;
    set_req(2, FPU_OP_MAX, 32'h3F80_0000, 32'h0000_0000);
    tick();
    check("t6_req2_ack", reqbus.req_input_ack, 4'b0100);
    check("t6_req2_grant", grant_id, 2);
    wait_rsp("t6", 20, cyc);
    check("t6_result", {reqbus.rsp_output_rdy, reqbus.rsp_error, reqbus.rsp_result},
          {4'b0100, 1'b0, 32'h3F80_0000});
    finish_op("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
